// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, operand classes and loader FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package fp32_pkg;

   localparam int          SIGN_W  = 1;
   localparam int          EXP_W   = 8;
   localparam int          MANT_W  = 23;
   localparam int          BIAS    = 127;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ZERO   = 2'b00,
      FINITE = 2'b01,
      INF    = 2'b10,
      NAN    = 2'b11
   } fp_class_t;

   typedef enum logic [1:0] {
      COLLECT = 2'b00,
      ISSUE   = 2'b01,
      RESULT  = 2'b10
   } loader_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Classifies an FP32 word as zero / finite (incl. subnormal) / infinity / NaN.
// Latency: combinational.
// Backpressure: none.
// Ports: value (32-bit FP32 word) in, cls (fp_class_t) out.
module fp32_classify
   import fp32_pkg::*;
(
   input  logic [31:0] value,
   output fp_class_t   cls
);

   logic [EXP_W-1:0]  exp_f;
   logic [MANT_W-1:0] mant_f;
   logic              unused_sign;

   assign exp_f       = value[MANT_W +: EXP_W];
   assign mant_f      = value[MANT_W-1:0];
   // Sign does not affect the class.
   assign unused_sign = value[31];

   always_comb begin
      cls = FINITE;
      if (exp_f == EXP_MAX) begin
         cls = (mant_f == '0) ? INF : NAN;
      end else if (exp_f == '0 && mant_f == '0) begin
         cls = ZERO;
      end
   end

endmodule

// File: rtl/fp_operand_loader.sv
// Assembles two FP32 operands from a byte stream, issues them to a combinational multiplier, holds the product.
// Latency: op_valid the cycle after byte 7 is accepted; res_valid the cycle after the op handshake (10 cycles/product min).
// Backpressure: byte_ready low outside COLLECT; op_valid/res_valid held until op_ready/res_ready.
// Ports: clk, rst_n (async active-low); byte_valid/byte_data/byte_ready in-stream; op_a/op_b/op_valid/op_ready
// and res_in to/from the multiplier; res_data/res_valid/res_ready result; busy, err_timeout status.
// Optional: FP_LOADER_CLASSIFY_EN adds class_a/class_b operand class outputs.
module fp_operand_loader
   import fp32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        op_valid,
   input  logic        op_ready,
   input  logic [31:0] res_in,
   output logic [31:0] res_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy,
`ifdef FP_LOADER_CLASSIFY_EN
   output logic [1:0]  class_a,
   output logic [1:0]  class_b,
`endif
   output logic        err_timeout
);

   // Keep the counter at least one bit wide even when the timeout is disabled.
   localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   loader_state_t     state_q, state_d;
   logic [2:0]        byte_cnt_q, byte_cnt_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [63:0]       opnd_q, opnd_d;
   logic [31:0]       res_data_q, res_data_d;
   logic              err_timeout_q, err_timeout_d;
   logic              byte_acc;
   logic              pair_done;

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      opnd_d        = opnd_q;
      res_data_d    = res_data_q;
      err_timeout_d = 1'b0;
      pair_done     = 1'b0;
      byte_ready    = (state_q == COLLECT);
      byte_acc      = byte_valid && byte_ready;

      case (state_q)
         COLLECT: begin
            if (byte_acc) begin
               // Byte 0 lands in op_a[31:24], byte 7 in op_b[7:0]; bit base is 8*(7-cnt).
               opnd_d[{~byte_cnt_q, 3'b000} +: 8] = byte_data;
               idle_cnt_d = '0;
               if (byte_cnt_q == 3'd7) begin
                  pair_done  = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = ISSUE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
               end
            end else if (TIMEOUT_CYCLES != 0 && byte_cnt_q != '0) begin
               // Partial operand contents are left in place; they are overwritten by the next pair.
               if (idle_cnt_q == IDLE_LAST) begin
                  byte_cnt_d    = '0;
                  idle_cnt_d    = '0;
                  err_timeout_d = 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         ISSUE: begin
            if (op_ready) begin
               res_data_d = res_in;
               state_d    = RESULT;
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= COLLECT;
         byte_cnt_q    <= '0;
         idle_cnt_q    <= '0;
         opnd_q        <= '0;
         res_data_q    <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         opnd_q        <= opnd_d;
         res_data_q    <= res_data_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign op_a        = opnd_q[63:32];
   assign op_b        = opnd_q[31:0];
   assign op_valid    = (state_q == ISSUE);
   assign res_valid   = (state_q == RESULT);
   assign res_data    = res_data_q;
   assign err_timeout = err_timeout_q;
   assign busy        = (state_q != COLLECT) || (byte_cnt_q != '0);

`ifdef FP_LOADER_CLASSIFY_EN
   fp_class_t cls_a_w, cls_b_w;
   fp_class_t class_a_q, class_a_d;
   fp_class_t class_b_q, class_b_d;

   // Classify the operands as they will be after this edge so the class lands with op_valid.
   fp32_classify u_cls_a (.value(opnd_d[63:32]), .cls(cls_a_w));
   fp32_classify u_cls_b (.value(opnd_d[31:0]),  .cls(cls_b_w));

   always_comb begin
      class_a_d = class_a_q;
      class_b_d = class_b_q;
      if (pair_done) begin
         class_a_d = cls_a_w;
         class_b_d = cls_b_w;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         class_a_q <= ZERO;
         class_b_q <= ZERO;
      end else begin
         class_a_q <= class_a_d;
         class_b_q <= class_b_d;
      end
   end

   assign class_a = class_a_q;
   assign class_b = class_b_q;
`endif

endmodule

// File: tb/tb_fp_operand_loader.sv
// Scoreboard bench for fp_operand_loader: stimulus pushes expected operand pairs and products,
// a negedge monitor pops and compares them on each op / result handshake.
// Directed checks cover reset state, latency, timeout, backpressure and mid-transaction reset.
module tb_fp_operand_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic [31:0] op_a, op_b;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [31:0] res_in;
   logic [31:0] res_data;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        busy;
   logic        err_timeout;
`ifdef FP_LOADER_CLASSIFY_EN
   logic [1:0]  class_a, class_b;
`endif

   always #5 clk = ~clk;

   fp_operand_loader #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
      .res_in(res_in), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy),
`ifdef FP_LOADER_CLASSIFY_EN
      .class_a(class_a), .class_b(class_b),
`endif
      .err_timeout(err_timeout)
   );

   // Stand-in multiplier: hand-computed products for the operand pairs used here.
   function automatic logic [31:0] mult_model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'hC1900000 && b == 32'h41180000) return 32'hC32B0000; // -18 * 9.5 = -171
      if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40000000; // 1 * 2 = 2
      if (a == 32'h00000000 && b == 32'h7F800000) return 32'h7FC00000; // 0 * inf = NaN
      if (a == 32'h7FC00000 && b == 32'h00000001) return 32'h7FC00000; // NaN * x = NaN
      return 32'h00000000;
   endfunction

   always_comb res_in = mult_model(op_a, op_b);

   int n_chk = 0;
   int n_pass = 0;
   int err_cnt = 0;
   int cyc = 0;
   logic [63:0] opq[$];
   logic [31:0] resq[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_bound(input string name);
      n_chk++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Monitor: compares on every handshake against the scoreboard queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (err_timeout) err_cnt++;
         if (op_valid && op_ready) begin
            if (opq.size() == 0) fail_bound("op_unexpected");
            else check("op_pair", {op_a, op_b}, opq.pop_front());
         end
         if (res_valid && res_ready) begin
            if (resq.size() == 0) fail_bound("res_unexpected");
            else check("res_data", {32'h0, res_data}, {32'h0, resq.pop_front()});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (byte_ready) begin ok = 1'b1; break; end
      end
      if (!ok) fail_bound("byte_accept");
      @(posedge clk);
      #1 byte_valid = 1'b0;
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input int gap);
      logic [63:0] w;
      w = {a, b};
      opq.push_back(w);
      resq.push_back(mult_model(a, b));
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            check("op_valid_before_last", {63'h0, op_valid}, 64'h0);
            check("busy_mid_pair", {63'h0, busy}, 64'h1);
         end
         send_byte(w[63 - 8*i -: 8]);
         if (i < 7) repeat (gap) begin @(posedge clk); #1; end
      end
      check("op_valid_after_last", {63'h0, op_valid}, 64'h1);
   endtask

   task automatic do_op();
      bit ok;
      ok = 1'b0;
      op_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (op_valid) begin ok = 1'b1; break; end
      end
      if (!ok) fail_bound("op_handshake");
      @(posedge clk);
      #1 op_ready = 1'b0;
   endtask

   task automatic do_res();
      bit ok;
      ok = 1'b0;
      res_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (res_valid) begin ok = 1'b1; break; end
      end
      if (!ok) fail_bound("res_handshake");
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_byte_ready"}, {63'h0, byte_ready}, 64'h1);
      check({tag, "_op_valid"}, {63'h0, op_valid}, 64'h0);
      check({tag, "_res_valid"}, {63'h0, res_valid}, 64'h0);
      check({tag, "_busy"}, {63'h0, busy}, 64'h0);
      check({tag, "_err"}, {63'h0, err_timeout}, 64'h0);
      check({tag, "_ops"}, {op_a, op_b}, 64'h0);
      check({tag, "_res_data"}, {32'h0, res_data}, 64'h0);
`ifdef FP_LOADER_CLASSIFY_EN
      check({tag, "_class"}, {60'h0, class_a, class_b}, 64'h0);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, e0;
      #3;
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Zero-wait pair: op_valid visible 8 edges after the first byte is presented.
      c0 = cyc;
      send_pair(32'hC1900000, 32'h41180000, 0);
      check("issue_latency", 64'(cyc - c0), 64'd8);
      do_op();
      check("res_valid_after_op", {63'h0, res_valid}, 64'h1);
      check("res_after_op", {32'h0, res_data}, 64'h00000000C32B0000);
      do_res();

      // Same pair with 3-cycle gaps: same product, no timeout.
      send_pair(32'hC1900000, 32'h41180000, 3);
      do_op();
      do_res();
      check("no_timeout_on_gaps", 64'(err_cnt), 64'd0);

      // Partial pair abandoned: one err_timeout pulse and byte_cnt back to 0.
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      check("busy_partial", {63'h0, busy}, 64'h1);
      e0 = err_cnt;
      repeat (20) begin @(posedge clk); #1; end
      check("timeout_pulses", 64'(err_cnt - e0), 64'd1);
      check("busy_after_timeout", {63'h0, busy}, 64'h0);
      send_pair(32'h3F800000, 32'h40000000, 0);
      check("ops_after_timeout", {op_a, op_b}, 64'h3F80000040000000);
      do_op();
      do_res();

      // ISSUE backpressure: bytes offered while op_ready is low must be ignored.
      send_pair(32'h3F800000, 32'h40000000, 0);
      for (int k = 0; k < 5; k++) begin
         byte_valid = k[0] ? 1'b0 : 1'b1;
         byte_data  = 8'hAA;
         @(negedge clk);
         check("issue_byte_ready", {63'h0, byte_ready}, 64'h0);
         check("issue_ops_stable", {op_a, op_b}, 64'h3F80000040000000);
         check("issue_op_valid", {63'h0, op_valid}, 64'h1);
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b0;
      do_op();
      do_res();
      check("no_bytes_consumed", {63'h0, busy}, 64'h0);
      check("ops_hold_after_result", {op_a, op_b}, 64'h3F80000040000000);

      // RESULT backpressure, then reset while a result is pending.
      send_pair(32'hC1900000, 32'h41180000, 0);
      do_op();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("result_hold_valid", {63'h0, res_valid}, 64'h1);
         check("result_hold_data", {32'h0, res_data}, 64'h00000000C32B0000);
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_result_reset");
      void'(resq.pop_front());
      @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef FP_LOADER_CLASSIFY_EN
      send_pair(32'h00000000, 32'h7F800000, 0);
      check("class_zero_inf", {60'h0, class_a, class_b}, {60'h0, 2'b00, 2'b10});
      do_op();
      do_res();
      send_pair(32'h7FC00000, 32'h00000001, 0);
      check("class_nan_sub", {60'h0, class_a, class_b}, {60'h0, 2'b11, 2'b01});
      do_op();
      do_res();
`endif

      repeat (2) @(posedge clk);
      #1;
      check("op_queue_drained", 64'(opq.size()), 64'd0);
      check("res_queue_drained", 64'(resq.size()), 64'd0);
      check("timeouts_total", 64'(err_cnt), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
